// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_pkg
// Brief   : Shared constants, arbiter FSM encoding and GF(2^8) helpers for the
//           AES-128 key-schedule arbiter and its key expander.
// Rev     : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam int NUM_KEY_WORDS = 44;
  localparam int KEY_BITS      = 128;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRIG  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GRANT = 2'd3;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box computed as the affine transform of the field inverse (x^254),
  // so no 256-entry table has to be maintained by hand.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] wd);
    return {sbox(wd[31:24]), sbox(wd[23:16]), sbox(wd[15:8]), sbox(wd[7:0])};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key.sv
`default_nettype none
// ============================================================================
// Module : aes_key
// Brief  : Iterative AES-128 key expander. One round (four words) is produced
//          per clock after trigger; done pulses for one cycle when word 43 is
//          written. Word i of the schedule sits at w_o[32*i +: 32].
// Rev    : 1.0  initial release
// ============================================================================
module aes_key
  import aes_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger_i,
  input  logic [KEY_BITS-1:0]           key_i,
  output logic                          done_o,
  output logic [NUM_KEY_WORDS*32-1:0]   w_o
);

  logic [NUM_KEY_WORDS*32-1:0] w_q;
  logic [KEY_BITS-1:0]         prev_q;   // last four words, schedule layout
  logic [3:0]                  round_q;
  logic [7:0]                  rcon_q;
  logic                        run_q;
  logic                        done_q;

  logic [KEY_BITS-1:0]         key_chunk;
  logic [31:0]                 temp_w;
  logic [KEY_BITS-1:0]         next_w;

  // Key word 0 is the most significant 32 bits of the key but lives at the
  // lowest schedule position.
  assign key_chunk = {key_i[31:0], key_i[63:32], key_i[95:64], key_i[127:96]};

  // Next round: RotWord/SubWord/Rcon on the last word, then the xor chain
  always_comb begin
    temp_w = sub_word({prev_q[119:96], prev_q[127:120]}) ^ {rcon_q, 24'h000000};
    next_w[31:0]   = prev_q[31:0]   ^ temp_w;
    next_w[63:32]  = prev_q[63:32]  ^ next_w[31:0];
    next_w[95:64]  = prev_q[95:64]  ^ next_w[63:32];
    next_w[127:96] = prev_q[127:96] ^ next_w[95:64];
  end

  // Round sequencing and done pulse; reset abandons any expansion in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      round_q <= 4'd0;
      rcon_q  <= 8'h00;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (trigger_i) begin
      prev_q  <= key_chunk;
      round_q <= 4'd1;
      rcon_q  <= 8'h01;
      run_q   <= 1'b1;
      done_q  <= 1'b0;
    end else if (run_q) begin
      prev_q  <= next_w;
      rcon_q  <= xtime(rcon_q);
      round_q <= round_q + 4'd1;
      run_q   <= (round_q != 4'd10);
      done_q  <= (round_q == 4'd10);
    end else begin
      done_q  <= 1'b0;
    end
  end

  // Schedule storage; deliberately not reset, contents meaningful only after done
  always_ff @(posedge clk) begin
    if (trigger_i) begin
      w_q[KEY_BITS-1:0] <= key_chunk;
    end else if (run_q) begin
      w_q[int'(round_q) * KEY_BITS +: KEY_BITS] <= next_w;
    end
  end

  assign done_o = done_q;
  assign w_o    = w_q;

endmodule
`default_nettype wire

// File: rtl/aes_key_arbiter.sv
`default_nettype none
// ============================================================================
// Module : aes_key_arbiter
// Brief  : Two-requester round-robin arbiter sharing one AES-128 key expander.
//          IDLE -> TRIG -> WAIT -> GRANT; grant is a level held while the
//          owner keeps its request high. A WAIT longer than TIMEOUT cycles
//          sets the sticky err flag.
//          Optional: AES_KEY_CACHE_EN keeps the last expanded key so a repeat
//          request for it is granted straight from IDLE.
// Rev    : 1.0  initial release
// ============================================================================
module aes_key_arbiter
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0,
  input  logic [KEY_BITS-1:0]         key0,
  output logic                        gnt0,
  input  logic                        req1,
  input  logic [KEY_BITS-1:0]         key1,
  output logic                        gnt1,
  output logic [NUM_KEY_WORDS*32-1:0] w,
  output logic                        busy,
  output logic                        err
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q,  last_d;
  logic [KEY_BITS-1:0] key_q,   key_d;     // operand presented to the expander
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                err_q,   err_d;

  logic                pick;
  logic [KEY_BITS-1:0] pick_key;
  logic                owner_req;
  logic                cache_hit;
  logic                exp_trig;
  logic                exp_done;

  // Round-robin choice: on a tie the requester not served last wins
  assign pick      = req1 & (~req0 | ~last_q);
  assign pick_key  = pick ? key1 : key0;
  assign owner_req = owner_q ? req1 : req0;
  assign exp_trig  = (state_q == ST_TRIG);

`ifdef AES_KEY_CACHE_EN
  logic valid_q, valid_d;

  assign cache_hit = valid_q && (pick_key == key_q);

  // Cache valid drops when a new key is loaded and rises on completion
  always_comb begin
    valid_d = valid_q;
    if (state_q == ST_IDLE && (req0 || req1) && !cache_hit) valid_d = 1'b0;
    else if (state_q == ST_WAIT && exp_done)                 valid_d = 1'b1;
  end

  // Cache valid register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Arbiter next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = pick;
          last_d  = pick;
          if (cache_hit) begin
            state_d = ST_GRANT;
          end else begin
            key_d   = pick_key;
            state_d = ST_TRIG;
          end
        end
      end
      ST_TRIG: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (exp_done) begin
          state_d = ST_GRANT;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GRANT: begin
        // An owner that left during TRIG/WAIT passes straight through
        if (!owner_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      key_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  aes_key u_key (
    .clk       (clk),
    .reset     (reset),
    .trigger_i (exp_trig),
    .key_i     (key_q),
    .done_o    (exp_done),
    .w_o       (w)
  );

  // Grants follow the owner's request combinationally so release is immediate
  assign gnt0 = (state_q == ST_GRANT) && !owner_q && req0;
  assign gnt1 = (state_q == ST_GRANT) &&  owner_q && req1;
  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule
`default_nettype wire

// File: doc/aes_key_arbiter.md
AES_KEY_ARBITER -- requirements
Module: aes_key_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; it forces all state to the reset values without waiting for clk.
REQ-003 SHALL have port req0, input, 1, requester 0 asks for, then holds, the key schedule.
REQ-004 SHALL have port key0, input, 128, requester 0 key; must be stable while req0 is high.
REQ-005 SHALL have port gnt0, output, 1, level signal: w holds the schedule for key0 and requester 0 owns it.
REQ-006 SHALL have ports req1, key1 and gnt1 (input 1, input 128, output 1), identical in behaviour to the requester-0 ports.
REQ-007 SHALL have port w, output, 1408, the 44-word schedule, word i at bits [32*i+:32].
REQ-008 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-009 SHALL have port err, output, 1, sticky timeout flag, cleared only by reset.
REQ-010 SHALL have parameter TIMEOUT, default 255: the maximum number of cycles allowed from trigger to expander done.

Function
REQ-011 SHALL implement FSM states IDLE, TRIG, WAIT and GRANT.
REQ-012 In IDLE, if any req is high, SHALL pick the owner and go to TRIG; with no req it SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: when both reqs are high, grant the requester not served last; the last-served bit resets to 1, so requester 0 wins the first tie.
REQ-014 In TRIG, SHALL register the owner's key into the expander, pulse trigger for exactly 1 cycle, and go to WAIT.
REQ-015 In WAIT, SHALL count cycles; on the expander's done pulse it SHALL go to GRANT.
REQ-016 In WAIT, if the count reaches TIMEOUT without done, SHALL set err, leave the cache invalid, and return to IDLE with no grant.
REQ-017 In GRANT, SHALL hold gntN=1 for the owner only; gnt0 and gnt1 SHALL never both be 1.
REQ-018 In GRANT, when the owner's req falls, SHALL drop gntN in the same cycle (combinational on req) and enter IDLE on the next edge.
REQ-019 IDLE re-arbitration SHALL add at least 1 cycle before the next grant.
REQ-020 The expander output SHALL reach w unmodified; w SHALL NOT be cleared on release.
REQ-021 If a requester changes its key while granted, SHALL ignore it; the requester must drop req and re-request.
REQ-022 A requester whose req drops while its expansion is in TRIG or WAIT SHALL still have the expansion completed and cached, then pass through GRANT for 0 cycles back to IDLE, with its gnt never asserted.

Reset
REQ-023 Reset SHALL force state IDLE, gnt0=gnt1=0, busy=0, err=0, last-served=1, cache invalid and the timeout counter to 0.
REQ-024 Reset SHALL also be driven to the expander; reset mid-WAIT SHALL abandon the expansion, and a post-reset request SHALL trigger a fresh expansion.
REQ-025 w is undefined after reset until the first completed expansion.

Configuration
REQ-026 With AES_KEY_CACHE_EN defined:
- SHALL keep a cached key and a valid bit, set when an expansion completes.
- In IDLE, a chosen owner whose key equals the cached key with valid=1 SHALL go directly to GRANT, so gnt rises 1 cycle after req is sampled, with no trigger.
REQ-027 Without AES_KEY_CACHE_EN, every grant SHALL pass through TRIG and WAIT, and no cache registers SHALL exist.

Structure
REQ-028 A shared package (aes_pkg) SHALL hold:
- the FSM state encoding;
- the constants NUM_KEY_WORDS=44 and KEY_BITS=128.
REQ-029 SHALL instantiate exactly one aes_key sub-module (the key expander) and no other sub-modules.

Verification
REQ-030 Request with key0=2b7e1516_28aed2a6_abf71588_09cf4f3c -> gnt0 high; w[31:0]=2b7e1516; w[1407:1376]=b6630ca6.
REQ-031 req0 and req1 asserted together from reset -> gnt0 first; drop req0 -> gnt1, then a second expansion, then gnt1 high.
REQ-032 With AES_KEY_CACHE_EN, re-request the same key0 -> gnt0 one cycle after req is sampled, no trigger pulse; without the macro -> a full expansion latency.
REQ-033 Assert reset 20 cycles into WAIT -> gnts, busy and err are 0 immediately (asynchronous); a new request gives a correct schedule.
REQ-034 Expander done forced low (stubbed) with TIMEOUT=16 -> err=1 after 16 WAIT cycles, FSM in IDLE, no gnt.
REQ-035 Alternate req0/req1 with different keys 4 times -> grants alternate and w matches the golden model every time.
